// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] PC_INC         = WORD_W'(4);
    localparam logic [WORD_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEF_EXC_VECTOR = 32'h0000_0080;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

    // Instruction word together with the address it was fetched from
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    // Force a byte address onto a word boundary
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register for an instruction that returned while IF/ID was stalled.
module fetch_buf
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         valid,
    output fetch_entry_t dout
);

    // Clear wins over load; payload only changes on load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem request
// at a time and feeds the IF/ID slot with stall back-pressure and redirect squash.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] pc,
    output logic        misalign_exc
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pend_pc_q, pend_pc_d;
    logic              drop_q, drop_d;

    logic [WORD_W-1:0] redir_target;
    logic              redir_misalign;

    logic              buf_load, buf_clear;
    logic              take_rdata, take_buf;
    logic              buf_valid;
    fetch_entry_t      buf_din, buf_dout;

    logic              consume;
    logic              if_valid_d;
    logic [WORD_W-1:0] if_instr_d, if_pc_d;
    logic              imem_req_d;
    logic              misalign_exc_d;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_misalign = |redirect_pc[1:0];
    assign redir_target   = redir_misalign ? EXC_VECTOR : redirect_pc;
`else
    logic unused_trap;
    assign redir_misalign = 1'b0;
    assign redir_target   = word_align(redirect_pc);
    assign unused_trap    = ^{redirect_pc[1:0], EXC_VECTOR};
`endif

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign buf_din   = '{instr: imem_rdata, pc: pend_pc_q};

    fetch_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (buf_din),
        .valid (buf_valid),
        .dout  (buf_dout)
    );

    // State, PC, pending address and squash flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            drop_q    <= drop_d;
        end
    end

    // Next state and datapath control; redirect overrides stall and handshakes
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        drop_d     = drop_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        take_rdata = 1'b0;
        take_buf   = 1'b0;

        if (redirect) begin
            pc_d      = redir_target;
            buf_clear = 1'b1;
        end

        case (state_q)
            IDLE: state_d = ISSUE;
            ISSUE: begin
                if (imem_ack) begin
                    state_d = WAIT;
                    if (redirect) begin
                        drop_d = 1'b1;
                    end else begin
                        pend_pc_d = pc_q;
                        pc_d      = pc_q + PC_INC;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = ISSUE;
                    drop_d  = 1'b0;
                    if (!redirect && !drop_q) begin
                        if (!if_valid || !stall) begin
                            take_rdata = 1'b1;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = HOLD;
                        end
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = ISSUE;
                end else if (!stall) begin
                    take_buf  = 1'b1;
                    buf_clear = 1'b1;
                    state_d   = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // IF/ID slot, request and trap next values
    always_comb begin
        consume        = if_valid && !stall;
        if_valid_d     = if_valid && !consume;
        if_instr_d     = if_instr;
        if_pc_d        = if_pc;
        imem_req_d     = (state_d == ISSUE);
        misalign_exc_d = redirect && redir_misalign;

        if (take_rdata) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = pend_pc_q;
        end else if (take_buf && buf_valid) begin
            if_valid_d = 1'b1;
            if_instr_d = buf_dout.instr;
            if_pc_d    = buf_dout.pc;
        end

        if (redirect) begin
            if_valid_d = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid     <= 1'b0;
            if_instr     <= '0;
            if_pc        <= '0;
            imem_req     <= 1'b0;
            misalign_exc <= 1'b0;
        end else begin
            if_valid     <= if_valid_d;
            if_instr     <= if_instr_d;
            if_pc        <= if_pc_d;
            imem_req     <= imem_req_d;
            misalign_exc <= misalign_exc_d;
        end
    end

endmodule
